// File: rtl/cycle_sequencer.sv
// rtl/cycle_sequencer.sv - opcode-fetch / M-cycle / T-step timing generator and opcode field decoder
// Drives one-hot step, M-cycle and opcode-field buses for the group microcode blocks.
module cycle_sequencer #(
  parameter int MAX_MCYCLES = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset_n,
  input  logic                   i_Fetch,
  input  logic                   i_Wait,
  input  logic [7:0]             i_Bus_Data,
  output logic                   o_Active,
  output logic                   o_Opcode_Fetch,
  output logic [3:0]             o_Cycle_Step,
  output logic [MAX_MCYCLES-1:0] o_Cycle_Count,
  output logic [7:0]             o_IR,
  output logic [3:0]             o_X,
  output logic [7:0]             o_Y,
  output logic [7:0]             o_Z,
  output logic [3:0]             o_P,
  output logic [1:0]             o_Q,
  output logic                   o_Overrun
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t state;
  logic   fetch_pending;
  logic   end_fetch;

  function automatic logic [3:0] onehot4(input logic [1:0] v);
    onehot4 = 4'b0001 << v;
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] v);
    onehot8 = 8'h01 << v;
  endfunction

  // A Fetch request seen earlier in the M-cycle still ends it at T4.
  assign end_fetch      = fetch_pending | i_Fetch;
  assign o_Active       = (state == EXEC);
  assign o_Opcode_Fetch = (state == FETCH);

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state         <= FETCH;
      fetch_pending <= 1'b0;
      o_Cycle_Step  <= 4'b0001;
      o_Cycle_Count <= '0;
      o_IR          <= 8'h00;
      o_X           <= 4'b0001;
      o_Y           <= 8'h01;
      o_Z           <= 8'h01;
      o_P           <= 4'b0001;
      o_Q           <= 2'b01;
      o_Overrun     <= 1'b0;
    end else if (!i_Wait) begin
      o_Cycle_Step <= {o_Cycle_Step[2:0], o_Cycle_Step[3]};
      if (state == FETCH) begin
        if (o_Cycle_Step[3]) begin
          // Fields are registered alongside IR so they are valid on the first EXEC cycle.
          o_IR          <= i_Bus_Data;
          o_X           <= onehot4(i_Bus_Data[7:6]);
          o_Y           <= onehot8(i_Bus_Data[5:3]);
          o_Z           <= onehot8(i_Bus_Data[2:0]);
          o_P           <= onehot4(i_Bus_Data[5:4]);
          o_Q           <= 2'b01 << i_Bus_Data[3];
          o_Cycle_Count <= {{(MAX_MCYCLES-1){1'b0}}, 1'b1};
          fetch_pending <= 1'b0;
          state         <= EXEC;
        end
      end else begin
        if (o_Cycle_Step[3]) begin
          fetch_pending <= 1'b0;
          if (end_fetch) begin
            state         <= FETCH;
            o_Cycle_Count <= '0;
          end else if (!o_Cycle_Count[MAX_MCYCLES-1]) begin
            o_Cycle_Count <= o_Cycle_Count << 1;
          end else begin
            o_Overrun     <= 1'b1;
            state         <= FETCH;
            o_Cycle_Count <= '0;
          end
        end else if (i_Fetch) begin
          fetch_pending <= 1'b1;
        end
      end
    end
  end

endmodule
